// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit, 7-segment + DP display.
// Each digit slot is BLANK_CYCLES dark cycles (ghost suppression) followed by
// ON_CYCLES lit cycles. The segment pattern is captured when the digit lights,
// so changes on the seg inputs only take effect in the next slot for that digit.
//
// Ports
//   Clk100M   : clock, all state updates on its rising edge
//   Reset     : asynchronous active-high reset
//   en        : scan enable, 0 forces the display dark and holds digitIdx
//   seg0..3   : per-digit segment patterns, 1 = lit, bit 7 = decimal point
//   an        : anode selects, active-low, an[i] selects digit i
//   cat       : segment cathodes, active-low
//   digitIdx  : digit currently owning the scan slot
//   frameTick : one-cycle pulse when digit 3 finishes and the scan wraps to 0
module seg_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned ON_CYCLES    = 99000
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       en,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
  output logic [3:0] an,
  output logic [7:0] cat,
  output logic [1:0] digitIdx,
  output logic       frameTick
);

  localparam int unsigned MaxCycles = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  // $clog2(N) bits cover 0..N-1, the largest terminal count of either state.
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);

  typedef enum logic {
    StBlank,
    StOn
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      snap_q;

  logic [7:0] seg_sel;
  logic [3:0] an_sel;

  // Pattern and anode for the digit about to be lit.
  always_comb begin
    seg_sel = 8'h00;
    unique case (digitIdx)
      2'd0: seg_sel = seg0;
      2'd1: seg_sel = seg1;
      2'd2: seg_sel = seg2;
      2'd3: seg_sel = seg3;
      default: seg_sel = 8'h00;
    endcase
    an_sel = ~(4'b0001 << digitIdx);
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state_q   <= StBlank;
      cnt_q     <= '0;
      snap_q    <= 8'h00;
      digitIdx  <= 2'd0;
      an        <= 4'hF;
      cat       <= 8'hFF;
      frameTick <= 1'b0;
    end else begin
      frameTick <= 1'b0;
      if (!en) begin
        // Dark and restart the blank period; digitIdx is held so an
        // interrupted digit is rescanned on resume.
        state_q <= StBlank;
        cnt_q   <= '0;
        an      <= 4'hF;
        cat     <= 8'hFF;
      end else begin
        unique case (state_q)
          StBlank: begin
            an  <= 4'hF;
            cat <= 8'hFF;
            if (cnt_q == BlankLast) begin
              state_q <= StOn;
              cnt_q   <= '0;
              snap_q  <= seg_sel;
              an      <= an_sel;
              cat     <= ~seg_sel;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StOn: begin
            cat <= ~snap_q;
            if (cnt_q == OnLast) begin
              state_q   <= StBlank;
              cnt_q     <= '0;
              an        <= 4'hF;
              cat       <= 8'hFF;
              digitIdx  <= digitIdx + 2'd1;
              frameTick <= (digitIdx == 2'd3);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StBlank;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with BLANK_CYCLES=2, ON_CYCLES=3.
// The reference model tracks edges elapsed since the last resume point and
// derives digit, lit/dark and frame ticks from that count arithmetically.
module tb_seg_scan_driver;

  localparam int B = 2;
  localparam int O = 3;
  localparam int P = B + O;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] seg [4];
  logic [3:0] an;
  logic [7:0] cat;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int total  = 0;
  int passed = 0;

  // Reference model state.
  int         m_t;     // enabled edges since reset / last en=0 edge
  int         m_d0;    // digit index at that resume point
  logic [7:0] m_snap;  // pattern captured when the current digit lit
  logic       m_ft;

  seg_scan_driver #(
    .BLANK_CYCLES(B),
    .ON_CYCLES   (O)
  ) dut (
    .Clk100M  (clk),
    .Reset    (rst),
    .en       (en),
    .seg0     (seg[0]),
    .seg1     (seg[1]),
    .seg2     (seg[2]),
    .seg3     (seg[3]),
    .an       (an),
    .cat      (cat),
    .digitIdx (digit_idx),
    .frameTick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_digit();
    return (m_d0 + m_t / P) % 4;
  endfunction

  function automatic bit m_lit();
    return (m_t % P) >= B;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_ft = 1'b0;
    if (rst) begin
      m_t    = 0;
      m_d0   = 0;
      m_snap = 8'h00;
    end else if (!en) begin
      m_d0 = m_digit();
      m_t  = 0;
    end else begin
      m_t++;
      if (m_t % P == B) m_snap = seg[m_digit()];
      if (m_t % P == 0 && ((m_d0 + m_t / P - 1) % 4) == 3) m_ft = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [3:0] sel;
    logic [3:0] exp_an;
    logic [7:0] exp_cat;
    sel     = 4'b0001 << m_digit();
    exp_an  = m_lit() ? ~sel : 4'hF;
    exp_cat = m_lit() ? ~m_snap : 8'hFF;
    check("an", {4'h0, an}, {4'h0, exp_an});
    check("cat", cat, exp_cat);
    check("digitIdx", {6'h0, digit_idx}, 8'(m_digit()));
    check("frameTick", {7'h0, frame_tick}, {7'h0, m_ft});
    check("onehot_an", {7'h0, ($countones(~an) <= 1)}, 8'h01);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Advance until digit d is lit per the model; an expired bound is a failure.
  task automatic wait_lit(input int d);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_lit() && m_digit() == d) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (found) passed++;
    else $error("FAIL wait_lit: digit %0d not lit within 60 cycles, observed an %h", d, an);
  endtask

  initial begin
    int ticks;
    rst    = 1'b1;
    en     = 1'b1;
    seg[0] = 8'h3F;
    seg[1] = 8'h06;
    seg[2] = 8'h5B;
    seg[3] = 8'h4F;
    m_t    = 0;
    m_d0   = 0;
    m_snap = 8'h00;
    m_ft   = 1'b0;
    tick();
    tick();
    check("reset_an", {4'h0, an}, 8'h0F);
    check("reset_cat", cat, 8'hFF);

    // Release reset: dark 2 cycles, digit 0 lit 3 cycles with cat=C0, then dark.
    rst = 1'b0;
    tick();
    check("rel_dark", {4'h0, an}, 8'h0F);
    tick();
    check("rel_an0", {4'h0, an}, 8'h0E);
    check("rel_cat0", cat, 8'hC0);
    tick();
    tick();
    check("rel_hold_cat", cat, 8'hC0);
    tick();
    check("rel_off", {4'h0, an}, 8'h0F);

    // Free run with one-hot segment patterns; 40 cycles hold exactly two frames.
    seg[0] = 8'h01;
    seg[1] = 8'h02;
    seg[2] = 8'h04;
    seg[3] = 8'h08;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_tick) ticks++;
    end
    check("frame_count", 8'(ticks), 8'd2);

    // Segment change during digit-1 ON is deferred to the next digit-1 slot.
    seg[1] = 8'h06;
    wait_lit(1);
    seg[1] = 8'h7F;
    tick();
    check("defer_cat", cat, 8'hF9);
    tick();
    wait_lit(2);
    wait_lit(1);
    check("next_slot_cat", cat, 8'h80);

    // Drop en mid digit-2 ON: dark, index held, then full blank and rescan of 2.
    wait_lit(2);
    en = 1'b0;
    tick();
    check("en_off_an", {4'h0, an}, 8'h0F);
    check("en_off_idx", {6'h0, digit_idx}, 8'd2);
    for (int i = 0; i < 4; i++) tick();
    en = 1'b1;
    tick();
    tick();
    check("resume_an2", {4'h0, an}, 8'h0B);
    tick();
    tick();

    // Randomised patterns and enable drops against the model.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) seg[k] = 8'($urandom);
      en = ($urandom_range(15) != 0);
      tick();
    end
    en = 1'b1;

    // Asynchronous reset between edges darkens immediately.
    wait_lit(3);
    #2;
    rst = 1'b1;
    #1;
    check("async_an", {4'h0, an}, 8'h0F);
    check("async_cat", cat, 8'hFF);
    check("async_idx", {6'h0, digit_idx}, 8'h00);
    check("async_ft", {7'h0, frame_tick}, 8'h00);
    tick();
    rst = 1'b0;
    seg[0] = 8'h3F;
    tick();
    tick();
    check("recover_an", {4'h0, an}, 8'h0E);
    check("recover_cat", cat, 8'hC0);
    for (int i = 0; i < 10; i++) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
